// File: rtl/overlap_pkg.sv
// overlap_pkg: shared defaults, frame flag positions and FSM states for overlap_add
package overlap_pkg;
    localparam int HALF_DEF   = 18;
    localparam int DATA_W_DEF = 65;
    localparam int FIRST      = 0;
    localparam int LAST       = 1;
    typedef enum logic {ADD, STORE} state_e;
endpackage

// File: rtl/overlap_buffer.sv
// overlap_buffer: HALF-deep history of second-half samples, sync write, comb read
module overlap_buffer #(
    parameter int HALF   = 18,
    parameter int DATA_W = 65,
    parameter int IW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [HALF];

    always_ff @(posedge clk)
        if (we) mem_q[idx] <= wdata;

    assign rdata = mem_q[idx];
endmodule

// File: rtl/overlap_add.sv
// overlap_add: IMDCT overlap-add, first half of each frame summed with stored second half of the previous one
// Define OVERLAP_SAT_EN to saturate the sum instead of wrapping it.
module overlap_add
    import overlap_pkg::*;
#(
    parameter int HALF   = HALF_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        in_overlap_firstSequence,
    input  logic              in_overlap_valid,
    output logic              in_overlap_ready,
    input  logic [DATA_W-1:0] in_overlap_pcmSample,
    output logic [DATA_W-1:0] out_overlap_pcmSample,
    output logic              out_overlap_valid,
    input  logic              out_overlap_ready
);
    localparam int IW = HALF > 1 ? $clog2(HALF) : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [1:0]          flags_q, flags_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   hist_rd, hist_wd, addend, sum_res;
    logic                hist_we, in_xfer, frame_start, idx_last;
    logic [1:0]          cur_flags;
    logic signed [DATA_W:0] sum;

    overlap_buffer #(.HALF(HALF), .DATA_W(DATA_W), .IW(IW)) u_buf (
        .clk   (clk),
        .we    (hist_we),
        .idx   (idx_q),
        .wdata (hist_wd),
        .rdata (hist_rd)
    );

    always_comb begin
        frame_start      = state_q == ADD && idx_q == '0;
        idx_last         = idx_q == IW'(HALF - 1);
        // the first sample of a frame must see its own flags, not last frame's
        cur_flags        = frame_start ? in_overlap_firstSequence : flags_q;
        in_overlap_ready = !reset && (state_q == STORE || !out_valid_q || out_overlap_ready);
        in_xfer          = in_overlap_valid && in_overlap_ready;
        addend           = cur_flags[FIRST] ? '0 : hist_rd;
        sum              = $signed({in_overlap_pcmSample[DATA_W-1], in_overlap_pcmSample})
                         + $signed({addend[DATA_W-1], addend});
`ifdef OVERLAP_SAT_EN
        sum_res = sum[DATA_W] == sum[DATA_W-1] ? sum[DATA_W-1:0]
                : sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
        sum_res = sum[DATA_W-1:0];
`endif
        hist_we     = in_xfer && state_q == STORE;
        hist_wd     = cur_flags[LAST] ? '0 : in_overlap_pcmSample;
        state_d     = state_q;
        idx_d       = idx_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q && !out_overlap_ready;
        out_data_d  = out_data_q;
        if (in_xfer) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) state_d = state_q == ADD ? STORE : ADD;
            if (frame_start) flags_d = in_overlap_firstSequence;
            if (state_q == ADD) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_res;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ADD;
            idx_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_overlap_valid     = out_valid_q;
    assign out_overlap_pcmSample = out_data_q;
endmodule

// File: tb/tb_overlap_add.sv
// tb_overlap_add: random and directed frames against a frame-level overlap-add model with a scoreboard
module tb_overlap_add;
    localparam int H = 18;
    localparam int W = 65;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   in_flags = 2'b00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         man_ready = 1'b1;
    logic         rnd_ready = 1'b1;
    logic         rand_bp = 1'b0;

    int total = 0;
    int bad = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] hist_m [H];
    logic [W-1:0] frame_d [2*H];

    assign out_ready = rand_bp ? rnd_ready : man_ready;

    overlap_add #(.HALF(H), .DATA_W(W)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_overlap_firstSequence (in_flags),
        .in_overlap_valid         (in_valid),
        .in_overlap_ready         (in_ready),
        .in_overlap_pcmSample     (in_data),
        .out_overlap_pcmSample    (out_data),
        .out_overlap_valid        (out_valid),
        .out_overlap_ready        (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = $urandom_range(0, 3) != 0;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Signed sum of two W-bit samples, clamped or wrapped to W bits
    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W+1:0] s, hi, lo;
        s  = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        hi = $signed({3'b000, {(W-1){1'b1}}});
        lo = -hi - 1;
`ifdef OVERLAP_SAT_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`endif
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic model_frame(input logic [1:0] f);
        for (int i = 0; i < H; i++) exp_q.push_back(ref_add(frame_d[i], f[0] ? '0 : hist_m[i]));
        for (int i = 0; i < H; i++) hist_m[i] = f[1] ? '0 : frame_d[H+i];
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] f);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_flags = f;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("input_accept", {{(W-1){1'b0}}, acc}, {{(W-1){1'b0}}, 1'b1});
    endtask

    task automatic send_range(input int lo, input int hi, input logic [1:0] f);
        for (int i = lo; i <= hi; i++) send(frame_d[i], f);
    endtask

    task automatic run_frame(input logic [1:0] f);
        model_frame(f);
        send_range(0, 2*H-1, f);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", out_data, 'x);
            else chk("output", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] held, sat_exp;
        for (int i = 0; i < H; i++) hist_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {{(W-1){1'b0}}, out_valid}, '0);
        chk("reset_data", out_data, '0);
        chk("reset_ready", {{(W-1){1'b0}}, in_ready}, '0);
        reset = 1'b0;

        // first frame 1..36
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'(i + 1);
        model_frame(2'b01);
        send(frame_d[0], 2'b01);
        chk("latency_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        chk("latency_data", out_data, W'(1));
        send_range(1, 2*H-1, 2'b01);

        // all-100 frame -> 119..136
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'(100);
        run_frame(2'b00);

        // backpressure in ADD, then stalled output across STORE
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'($urandom_range(0, 1000));
        model_frame(2'b00);
        send_range(0, 4, 2'b00);
        man_ready = 1'b0;
        in_valid = 1'b1;
        in_data = frame_d[5];
        held = out_data;
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready", {{(W-1){1'b0}}, in_ready}, '0);
            chk("stall_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
            chk("stall_data", out_data, held);
        end
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        send_range(5, H-1, 2'b00);
        man_ready = 1'b0;
        held = out_data;
        send_range(H, 2*H-1, 2'b00);
        chk("store_stall_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        chk("store_stall_data", out_data, held);
        man_ready = 1'b1;

        // last frame then a plain frame of 7s
        for (int i = 0; i < 2*H; i++) frame_d[i] = rnd();
        run_frame(2'b10);
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'(7);
        run_frame(2'b00);

        // overflow: history at max positive, input 1
        for (int i = 0; i < 2*H; i++) frame_d[i] = i < H ? rnd() : {1'b0, {(W-1){1'b1}}};
        run_frame(2'b01);
        for (int i = 0; i < 2*H; i++) frame_d[i] = i < H ? W'(1) : rnd();
        model_frame(2'b00);
        send(frame_d[0], 2'b00);
`ifdef OVERLAP_SAT_EN
        sat_exp = {1'b0, {(W-1){1'b1}}};
`else
        sat_exp = {1'b1, {(W-1){1'b0}}};
`endif
        chk("overflow", out_data, sat_exp);
        send_range(1, 2*H-1, 2'b00);

        // random frames with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] f;
            f = k == 0 ? 2'b01 : 2'($urandom_range(0, 3));
            for (int i = 0; i < 2*H; i++) frame_d[i] = k[0] ? rnd() : W'($urandom_range(0, 255));
            run_frame(f);
        end
        repeat (4) @(posedge clk);
        #1;
        rand_bp = 1'b0;
        man_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // reset at idx 9 of STORE with an output pending
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'($urandom_range(1, 1000));
        model_frame(2'b00);
        send_range(0, H-1, 2'b00);
        man_ready = 1'b0;
        send_range(H, H+8, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_valid", {{(W-1){1'b0}}, out_valid}, '0);
        chk("midreset_data", out_data, '0);
        chk("midreset_ready", {{(W-1){1'b0}}, in_ready}, '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        man_ready = 1'b1;
        for (int i = 0; i < 2*H; i++) frame_d[i] = W'(5);
        run_frame(2'b01);

        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/overlap_add.md
OVERLAP_ADD -- requirements
Module: overlap_add

Interface
REQ-001 The block SHALL have parameter HALF, default 18, meaning samples per half-frame; a full input frame is 2*HALF samples.
REQ-002 The block SHALL have parameter DATA_W, default 65, meaning the signed sample width.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_overlap_firstSequence  input  2  frame flags, sampled with the first sample of each frame: bit0 = first frame, bit1 = last frame.
REQ-006 in_overlap_valid  input  1  the input sample is valid.
REQ-007 in_overlap_ready  output  1  the block accepts the input sample.
REQ-008 in_overlap_pcmSample  input  DATA_W  the signed IMDCT output sample.
REQ-009 out_overlap_pcmSample  output  DATA_W  the signed overlap-added PCM sample.
REQ-010 out_overlap_valid  output  1  the output sample is valid.
REQ-011 out_overlap_ready  input  1  the downstream block accepts the output sample.

Function
REQ-012 An input transfer SHALL occur on a cycle with in_overlap_valid=1 and in_overlap_ready=1; an output transfer SHALL occur on a cycle with out_overlap_valid=1 and out_overlap_ready=1.
REQ-013 The FSM SHALL have two states, with index counter idx running 0..HALF-1:
- ADD (reset state): in_overlap_ready = !out_overlap_valid || out_overlap_ready.
- STORE: in_overlap_ready = 1.
REQ-014 Each input transfer SHALL increment idx; when idx=HALF-1, idx SHALL wrap to 0 and the FSM SHALL toggle between ADD and STORE.
REQ-015 In ADD, an input transfer SHALL load out_overlap_pcmSample with in + hist[idx] and set out_overlap_valid=1 on the next cycle (latency 1).
- hist[idx] SHALL be treated as 0 when the current frame's first flag is set.
REQ-016 In STORE, an input transfer SHALL write hist[idx] <= in and SHALL produce no output.
- If the current frame's last flag is set, it SHALL write hist[idx] <= 0 instead.
REQ-017 The flags SHALL be captured when idx=0 in ADD and an input transfer occurs, and SHALL be held for the full 2*HALF samples of that frame.
REQ-018 out_overlap_valid SHALL stay high and out_overlap_pcmSample SHALL stay stable until an output transfer occurs.
- On the cycle of that transfer, a simultaneous ADD input SHALL reload the output register, giving back-to-back throughput.
- Otherwise out_overlap_valid SHALL clear.
REQ-019 Each 2*HALF-sample input frame SHALL produce exactly HALF output samples, in index order.
REQ-020 The flag value 2'b11 SHALL apply both rules: zero history in, zero history out.

Reset
REQ-021 Assertion of reset SHALL force, asynchronously and at any time including mid-frame: state=ADD, idx=0, out_overlap_valid=0, out_overlap_pcmSample=0, and captured flags=0.
REQ-022 While reset is asserted, in_overlap_ready SHALL be 0.
REQ-023 Reset SHALL leave hist contents undefined; software SHALL start with a first frame after reset, and the bench SHALL check only outputs from first frames onward.

Configuration
REQ-024 With OVERLAP_SAT_EN defined, the ADD sum SHALL saturate to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 Without OVERLAP_SAT_EN, the ADD sum SHALL be truncated to DATA_W bits (two's-complement wrap).

Structure
REQ-026 Package overlap_pkg SHALL hold:
- default HALF and DATA_W;
- the flag bit positions (FIRST=0, LAST=1);
- the FSM state enum {ADD, STORE}.
REQ-027 The history SHALL live in sub-module overlap_buffer: HALF x DATA_W, one synchronous write port, one combinational read port addressed by idx.
REQ-028 overlap_add SHALL contain the FSM, idx counter, flag register, adder/saturator and output register.

Verification
REQ-029 First frame, flags=01, inputs 1..36 with out_overlap_ready held at 1 -> outputs 1..18, one per cycle, latency 1; hist = 19..36.
REQ-030 Following frame, flags=00, all 36 inputs = 100 -> outputs 119..136.
REQ-031 Backpressure: out_overlap_ready=0 for 5 cycles during ADD -> in_overlap_ready=0, output held stable; no loss or duplication; STORE samples are still accepted while the output is stalled.
REQ-032 Last frame, flags=10, then next frame flags=00, inputs all 7 -> second frame outputs all 7.
REQ-033 Saturation, with DATA_W=65 and the macro on: hist = 2^64-1 plus input 1 -> output 2^64-1. With the macro off, the same stimulus -> output -2^64.
REQ-034 Reset asserted at idx=9 of STORE -> outputs cleared immediately. A following first frame of inputs 5 -> outputs 5 (x18).
